gcd_engine: RTL

//  Synthesizable, parametrised binary-GCD (Stein) coprocessor. Replaces the bench-only

---
 rtl/gcd_engine.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/gcd_engine.sv
// Binary-GCD (Stein) coprocessor with a start/ready/done handshake.
// Shift-and-subtract datapath only; no divider.
module gcd_engine #(
  parameter int WIDTH  = 6,
  parameter int ITER_W = 8
) (
  input  logic              clk_40mhz,
  input  logic              reset_i,
  input  logic              go_i,
  input  logic [WIDTH-1:0]  x_i,
  input  logic [WIDTH-1:0]  y_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [WIDTH-1:0]  d_o,
  output logic              zero_o,
  output logic [ITER_W-1:0] iter_o
);

  localparam int K_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    EVEN  = 3'd2,
    STRIP = 3'd3,
    SUB   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    x_q, x_d;
  logic [WIDTH-1:0]    y_q, y_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [ITER_W-1:0]   it_q, it_d;
  logic [WIDTH-1:0]    res_q, res_d;
  logic                rzero_q, rzero_d;
  logic                done_q;
  logic [WIDTH-1:0]    d_q;
  logic                zero_q;
  logic [ITER_W-1:0]   iter_q;

  function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
    return (&v) ? v : v + ITER_W'(1);
  endfunction

  always_ff @(posedge clk_40mhz) begin
    if (reset_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      it_q    <= '0;
      res_q   <= '0;
      rzero_q <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      zero_q  <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      it_q    <= it_d;
      res_q   <= res_d;
      rzero_q <= rzero_d;
      // Result registers load as DONE is left, so done_o and d_o change together.
      done_q  <= (state_q == DONE);
      if (state_q == DONE) begin
        d_q    <= res_q;
        zero_q <= rzero_q;
        iter_q <= it_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    it_d    = it_q;
    res_d   = res_q;
    rzero_d = rzero_q;
    unique case (state_q)
      IDLE: begin
        if (go_i) begin
          x_d     = x_i;
          y_d     = y_i;
          k_d     = '0;
          it_d    = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (x_q == '0 && y_q == '0) begin
          res_d   = '0;
          rzero_d = 1'b1;
          state_d = DONE;
        end else if (x_q == '0) begin
          res_d   = y_q;
          rzero_d = 1'b0;
          state_d = DONE;
        end else if (y_q == '0) begin
          res_d   = x_q;
          rzero_d = 1'b0;
          state_d = DONE;
        end else begin
          state_d = EVEN;
        end
      end
      EVEN: begin
        if (!x_q[0] && !y_q[0]) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + K_W'(1);
        end else begin
          state_d = STRIP;
        end
      end
      STRIP: begin
        if (!x_q[0])      x_d = x_q >> 1;
        else if (!y_q[0]) y_d = y_q >> 1;
        else              state_d = SUB;
      end
      SUB: begin
        it_d = sat_inc(it_q);
        // Both operands are odd here, so the difference is even and the shift is exact.
        if (x_q == y_q) begin
          res_d   = x_q << k_q;
          rzero_d = 1'b0;
          state_d = DONE;
        end else if (x_q > y_q) begin
          x_d     = (x_q - y_q) >> 1;
          state_d = STRIP;
        end else begin
          y_d     = (y_q - x_q) >> 1;
          state_d = STRIP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready_o = (state_q == IDLE);
  assign done_o  = done_q;
  assign d_o     = d_q;
  assign zero_o  = zero_q;
  assign iter_o  = iter_q;

endmodule
